// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: two write ports, NUM_RD read ports, and the clear/ready status.
interface reg_file_mp_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_RD = 2
);
    logic [1:0]               we;
    logic [2*ADDR_W-1:0]      wr_addr;
    logic [2*DATA_W-1:0]      wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     ready;
    logic                     clr_busy;

    modport master (
        output we, wr_addr, wr_data, rd_addr,
        input  rd_data, ready, clr_busy
    );

    modport slave (
        input  we, wr_addr, wr_data, rd_addr,
        output rd_data, ready, clr_busy
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: N combinational read ports with write bypass, two prioritised
// write ports, optional hardwired zero entry, and a one-entry-per-cycle clear after reset.
module reg_file_mp #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_mp_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic                ready_q, ready_d;
    logic                clr_busy_q, clr_busy_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];

    logic [ADDR_W-1:0]   wa     [2];
    logic [DATA_W-1:0]   wd     [2];
    logic [1:0]          wr_ok;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;

    // Unpack write ports; a write to entry 0 is dropped when it is hardwired to zero.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wa[p]    = bus.wr_addr[p*ADDR_W +: ADDR_W];
            wd[p]    = bus.wr_data[p*DATA_W +: DATA_W];
            wr_ok[p] = bus.we[p] && !((ZERO_REG != 0) && (wa[p] == '0));
        end
    end

    // Next-state, clear sequencing and array update; port 1 is applied last so it wins.
    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        ready_d    = ready_q;
        clr_busy_d = clr_busy_q;
        mem_d      = mem_q;
        case (state_q)
            ST_CLEAR: begin
                mem_d[clr_idx_q] = '0;
                clr_idx_d        = clr_idx_q + ADDR_W'(1);
                if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d    = ST_RUN;
                    ready_d    = 1'b1;
                    clr_busy_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (wr_ok[0]) mem_d[wa[0]] = wd[0];
                if (wr_ok[1]) mem_d[wa[1]] = wd[1];
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_idx_q  <= '0;
            ready_q    <= 1'b0;
            clr_busy_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            ready_q    <= ready_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    // The array holds its contents through reset; the clear sequencer owns initialisation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= mem_d;
        end
    end

    // Read ports: zero while clearing, then port-1 bypass, port-0 bypass, stored entry.
    always_comb begin
        rd_data_c = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            if (ready_q && !((ZERO_REG != 0) && (bus.rd_addr[j*ADDR_W +: ADDR_W] == '0))) begin
                if (wr_ok[1] && (wa[1] == bus.rd_addr[j*ADDR_W +: ADDR_W])) begin
                    rd_data_c[j*DATA_W +: DATA_W] = wd[1];
                end else if (wr_ok[0] && (wa[0] == bus.rd_addr[j*ADDR_W +: ADDR_W])) begin
                    rd_data_c[j*DATA_W +: DATA_W] = wd[0];
                end else begin
                    rd_data_c[j*DATA_W +: DATA_W] = mem_q[bus.rd_addr[j*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.ready    = ready_q;
    assign bus.clr_busy = clr_busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp (4 read ports, zero register on): directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural register-file model.
module tb_reg_file_mp;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_mp_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_RD(NR)) bus ();

    reg_file_mp #(.ADDR_W(AW), .DATA_W(DW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: clear completes on the DEPTH-th edge out of reset, then plain writes.
    logic [31:0] m_mem [DEPTH];
    int          m_cnt   = 0;
    bit          m_run   = 1'b0;
    bit          m_known = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_known = 1'b1;
            m_run   = 1'b0;
            m_cnt   = 0;
        end else if (m_known && !m_run) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_run = 1'b1;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
            end
        end else if (m_run) begin
            for (int p = 0; p < 2; p++) begin
                if (bus.we[p] && bus.wr_addr[p*AW +: AW] != 5'd0)
                    m_mem[bus.wr_addr[p*AW +: AW]] = bus.wr_data[p*DW +: DW];
            end
        end
    end

    function automatic logic [31:0] m_read(input int j);
        logic [4:0] a;
        a = bus.rd_addr[j*AW +: AW];
        if (!m_run || a == 5'd0) return 32'h0;
        if (bus.we[1] && bus.wr_addr[1*AW +: AW] == a) return bus.wr_data[1*DW +: DW];
        if (bus.we[0] && bus.wr_addr[0*AW +: AW] == a) return bus.wr_data[0*DW +: DW];
        return m_mem[a];
    endfunction

    always @(negedge clk) begin
        if (m_known) begin
            check("model_ready", 32'(bus.ready), 32'(m_run));
            check("model_clr_busy", 32'(bus.clr_busy), 32'(!m_run));
            for (int j = 0; j < NR; j++)
                check($sformatf("model_rd%0d", j), bus.rd_data[j*DW +: DW], m_read(j));
        end
    end

    function automatic logic [31:0] rd(input int j);
        return bus.rd_data[j*DW +: DW];
    endfunction

    task automatic drive_wr(input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
                            input logic [4:0] a1, input logic [31:0] d1);
        bus.we      = w;
        bus.wr_addr = {a1, a0};
        bus.wr_data = {d1, d0};
    endtask

    task automatic drive_rd(input logic [4:0] r0, input logic [4:0] r1,
                            input logic [4:0] r2, input logic [4:0] r3);
        bus.rd_addr = {r3, r2, r1, r0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after rst release until ready; optionally drops writes after a few edges.
    task automatic wait_ready(input string name, input int drop_we_at);
        int n;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (i == drop_we_at) bus.we = 2'b00;
            if (bus.ready) begin
                n = i;
                break;
            end
        end
        check(name, 32'(n), 32'd32);
    endtask

    initial begin
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        drive_rd(5'd0, 5'd0, 5'd0, 5'd0);
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_clr_busy", 32'(bus.clr_busy), 32'd1);
        step();
        rst = 1'b0;
        wait_ready("clear_len", 0);
        @(negedge clk);
        check("run_clr_busy", 32'(bus.clr_busy), 32'd0);
        step();

        // Every entry reads zero after the clear.
        for (int a = 0; a < DEPTH; a += 4) begin
            drive_rd(5'(a), 5'(a + 1), 5'(a + 2), 5'(a + 3));
            @(negedge clk);
            for (int j = 0; j < NR; j++) check("post_clear_zero", rd(j), 32'h0);
            step();
        end

        // Port-0 write with same-cycle bypass, then stored value.
        drive_wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        drive_rd(5'd5, 5'd5, 5'd0, 5'd1);
        @(negedge clk);
        check("bypass_p0", rd(0), 32'hDEADBEEF);
        check("bypass_p0_rd1", rd(1), 32'hDEADBEEF);
        step();
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        @(negedge clk);
        check("stored_5", rd(0), 32'hDEADBEEF);
        step();

        // Both ports to the same address: port 1 wins.
        drive_wr(2'b11, 5'd9, 32'h1111, 5'd9, 32'h2222);
        drive_rd(5'd9, 5'd5, 5'd9, 5'd0);
        @(negedge clk);
        check("bypass_p1_wins", rd(0), 32'h2222);
        step();
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        @(negedge clk);
        check("stored_9", rd(0), 32'h2222);
        check("stored_5_again", rd(1), 32'hDEADBEEF);
        step();

        // Writes to the zero register are discarded, including the bypass.
        drive_wr(2'b10, 5'd0, 32'h0, 5'd0, 32'hFFFF_FFFF);
        drive_rd(5'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        check("zero_bypass", rd(0), 32'h0);
        step();
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        @(negedge clk);
        check("zero_stored", rd(0), 32'h0);
        step();

        // Different addresses commit together; port-0 bypass when port 1 targets elsewhere.
        drive_wr(2'b11, 5'd8, 32'd7, 5'd3, 32'hAA);
        drive_rd(5'd8, 5'd3, 5'd4, 5'd9);
        @(negedge clk);
        check("dual_bypass_p0", rd(0), 32'd7);
        check("dual_bypass_p1", rd(1), 32'hAA);
        check("dual_unwritten", rd(2), 32'h0);
        step();
        drive_wr(2'b01, 5'd9, 32'd3, 5'd0, 32'h0);
        step();
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        drive_rd(5'd8, 5'd9, 5'd8, 5'd0);
        @(negedge clk);
        check("quad_rd0", rd(0), 32'd7);
        check("quad_rd1", rd(1), 32'd3);
        check("quad_rd2", rd(2), 32'd7);
        check("quad_rd3", rd(3), 32'd0);
        step();

        // Reset at clear step 10 restarts the clear; writes during the clear are lost.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        @(negedge clk);
        check("mid_clear_ready", 32'(bus.ready), 32'd0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_wr(2'b11, 5'd5, 32'h55, 5'd6, 32'h66);
        drive_rd(5'd5, 5'd6, 5'd8, 5'd9);
        @(negedge clk);
        check("clear_rd_zero", rd(0), 32'h0);
        check("clear_rd_zero_b", rd(1), 32'h0);
        wait_ready("clear_len_restart", 3);
        @(negedge clk);
        check("lost_5", rd(0), 32'h0);
        check("lost_6", rd(1), 32'h0);
        check("wiped_8", rd(2), 32'h0);
        check("wiped_9", rd(3), 32'h0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
